sfa_in_arbiter: RTL

//  Dynamic controller for the 4-way input switch (N/E/S/W -> one master port).
//  - Round-robins the four stream sources and drives the switch's 2-bit CONF select.
//  - Holds each grant for a burst of BURST_LEN beats, or until the granted source idles.
//  - Gates ready back to the sources and valid toward downstream: only the granted source completes beats.

---
 rtl/sfa_in_arbiter_pkg.sv | 19 +
 rtl/sfa_rr_picker.sv | 27 ++
 rtl/sfa_in_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sfa_in_arbiter_pkg.sv
// Shared constants for the 4-way input arbiter:
// direction codes, FSM encodings and a select decoder.
package sfa_in_arbiter_pkg;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  function automatic logic [3:0] dir_onehot(
    input logic [1:0] d
  );
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/sfa_rr_picker.sv
// Rotating-priority picker: first requester found
// at ptr+1, ptr+2, ... (mod 4).
module sfa_rr_picker (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] pick
);

  logic [1:0] base;
  logic [7:0] dbl;
  logic [3:0] rot;

  assign base = ptr + 2'd1;
  assign dbl  = {req, req};
  assign rot  = dbl[{1'b0, base} +: 4];
  assign any  = |req;

  // Scan from the far end so the nearest requester wins.
  always_comb begin
    pick = base;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) pick = base + 2'(i);
    end
  end

endmodule

// File: rtl/sfa_in_arbiter.sv
// Round-robin grant controller for the N/E/S/W input
// switch: drives CONF and gates the stream handshakes.
module sfa_in_arbiter
  import sfa_in_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 4
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       EN,
  input  logic       sn_tvalid,
  input  logic       se_tvalid,
  input  logic       ss_tvalid,
  input  logic       sw_tvalid,
  output logic       sn_tready,
  output logic       se_tready,
  output logic       ss_tready,
  output logic       sw_tready,
  output logic [1:0] CONF,
  input  logic       sx_tvalid,
  output logic       sx_tready,
  output logic       mo_tvalid,
  input  logic       mo_tready,
  output logic       LOCKED
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST =
    IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic          state_q, state_d;
  logic [1:0]    conf_q, conf_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [3:0] req;
  logic       any;
  logic [1:0] pick;
  logic       g_valid;
  logic       beat;
  logic       rel;
  logic       live;
  logic [3:0] rdy;

  assign req = {sw_tvalid, ss_tvalid, se_tvalid, sn_tvalid};

  sfa_rr_picker u_picker (
    .req  (req),
    .ptr  (ptr_q),
    .any  (any),
    .pick (pick)
  );

  assign g_valid = req[conf_q];
  assign beat    = g_valid & mo_tready;
  assign rel     = (beat && cnt_q == CNT_LAST)
                || (TO_EN && !g_valid && idle_q == IDLE_LAST);

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    unique case (state_q)
      ST_IDLE: begin
        if (EN && any) begin
          conf_d  = pick;
          ptr_d   = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (beat) cnt_d = cnt_q + 1'b1;
        if (g_valid) begin
          idle_d = '0;
        end else if (TO_EN && idle_q != IDLE_MAX) begin
          idle_d = idle_q + 1'b1;
        end
        if (rel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idle_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      conf_q  <= DIR_N;
      ptr_q   <= DIR_W;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

  // Reset cycle must not complete a beat, even mid-burst.
  assign live = state_q & ~ARESET;
  assign rdy  = {4{mo_tready & live}} & dir_onehot(conf_q);

  assign LOCKED    = state_q;
  assign CONF      = conf_q;
  assign mo_tvalid = sx_tvalid & live;
  assign sx_tready = mo_tready & live;
  assign sn_tready = rdy[DIR_N];
  assign se_tready = rdy[DIR_E];
  assign ss_tready = rdy[DIR_S];
  assign sw_tready = rdy[DIR_W];

endmodule
